logic_unit_scheduler: RTL and testbench
=======================================

Name: logic_unit_scheduler

Overview:
- Shares one combinational bitwise logic unit (AND/OR/XOR/NOR, WIDTH bits, with enable gating) among N_REQ requesters.
- Round-robin arbitration, per-requester valid/ready request handshake, single valid/ready response channel tagged with the requester ID.
- Sits between the ALU front-end issue ports and the shared bitwise datapath.
- Sequences the unit's enable so the unit sees operands only during its execute cycle.

Parameters:
- WIDTH, 32, operand and result width.
- N_REQ, 4, number of requesters; legal range 2..16.
- ID_W, $clog2(N_REQ), width of the requester ID.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester accept; at most one bit high.
- req_op  input  2*N_REQ  per-requester opcode, requester k at bits [2k+1:2k]: 00 AND, 01 OR, 10 XOR, 11 NOR.
- req_a  input  WIDTH*N_REQ  per-requester operand 1, requester k at slice k.
- req_b  input  WIDTH*N_REQ  per-requester operand 2, requester k at slice k.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  ID_W  index of the requester that owns the response.
- rsp_data  output  WIDTH  result.
- unit_enable  output  1  enable to the shared unit.
- unit_op  output  2  opcode to the shared unit.
- unit_a  output  WIDTH  operand 1 to the shared unit.
- unit_b  output  WIDTH  operand 2 to the shared unit.
- unit_o  input  WIDTH  combinational result from the shared unit.

Behaviour:
- Reset: state IDLE, rr_ptr=0, and every output at zero: req_ready, rsp_valid, rsp_id, rsp_data, unit_enable, unit_op, unit_a, unit_b. Reset overrides any in-flight operation; a reset during EXEC or RESP drops that operation with no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first requester with req_valid=1, searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - req_ready is combinational: one-hot on the winner, only in IDLE; all zero otherwise or when no req_valid is set.
  - Accept (req_valid & req_ready of the winner): latch op, a and b into unit_op/unit_a/unit_b and the winner index into the ID register.
  - On accept: rr_ptr <= (winner+1) mod N_REQ, go to EXEC.
  - No request: stay in IDLE; rr_ptr unchanged.
- EXEC (exactly 1 cycle):
  - unit_enable=1.
  - At the clock edge, rsp_data <= unit_o and rsp_id <= latched ID, then go to RESP.
  - Outside EXEC, unit_enable=0; unit_op/unit_a/unit_b hold their last latched values.
- RESP:
  - rsp_valid=1. rsp_id and rsp_data are held stable until the handshake.
  - rsp_ready=1: rsp_valid falls at the next edge and the FSM returns to IDLE.
  - rsp_ready=0: stay in RESP indefinitely; no req_ready is asserted (backpressure).
- Latency and throughput:
  - Accept edge to rsp_valid=1 is 2 cycles.
  - Minimum issue interval is 3 cycles: accept, EXEC, RESP with rsp_ready=1, then the next accept in IDLE.
- rsp_ready arriving before rsp_valid has no effect.
- req_valid may drop without acceptance; a requester is never granted unless its req_valid is high in the accept cycle.
- Fairness: once requester k is granted, every other continuously-valid requester is granted before k is granted again. Worst-case wait is (N_REQ-1) operations.
- rr_ptr wraps from N_REQ-1 to 0.
- Opcode values decode exactly as given for req_op. The scheduler does not compute results; rsp_data is always the captured unit_o.

Test Plan:
- Single requester: requester 0 issues OR, a=0xF0F0_0000, b=0x0000_0F0F, rsp_ready=1 -> req_ready[0] high in cycle 0; unit_enable high only in cycle 1; rsp_valid in cycle 2 with rsp_data=0xF0F0_0F0F and rsp_id=0; back in IDLE in cycle 3.
- Opcode sweep on requester 2 with a=0xFF00_FF00, b=0x0FF0_0FF0 -> AND 0x0F00_0F00; OR 0xFFF0_FFF0; XOR 0xF0F0_F0F0; NOR 0x000F_000F; rsp_id=2 each time.
- All four requesters hold req_valid=1 from reset, rsp_ready=1 -> grant order 0,1,2,3,0,1; each response carries the matching rsp_id; at most one req_ready bit high in any cycle.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises, with requester 1 pending -> rsp_data/rsp_id stable; req_ready=0 throughout; after rsp_ready=1, requester 1 accepted 1 cycle later.
- Reset mid-operation: assert rst during EXEC -> next cycle all outputs 0, no response produced; the next request from requester 3 with all requesters valid is granted after requester 0 (rr_ptr=0).
- Pointer wrap: only requesters 3 and 0 valid, starting with rr_ptr=3 -> grants alternate 3,0,3,0; unit_enable is never high outside EXEC.

Source files
------------

// File: rtl/logic_unit_scheduler_if.sv
// Bundles the requester, response and shared-unit signals of the logic unit scheduler.
// The scheduler is the slave; the issue ports, the consumer and the shared unit are the master.
interface logic_unit_scheduler_if #(
   parameter int WIDTH = 32,
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
);
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [2*N_REQ-1:0]     req_op;
   logic [WIDTH*N_REQ-1:0] req_a;
   logic [WIDTH*N_REQ-1:0] req_b;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [ID_W-1:0]        rsp_id;
   logic [WIDTH-1:0]       rsp_data;
   logic                   unit_enable;
   logic [1:0]             unit_op;
   logic [WIDTH-1:0]       unit_a;
   logic [WIDTH-1:0]       unit_b;
   logic [WIDTH-1:0]       unit_o;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready, unit_o,
      input  req_ready, rsp_valid, rsp_id, rsp_data, unit_enable, unit_op, unit_a, unit_b
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready, unit_o,
      output req_ready, rsp_valid, rsp_id, rsp_data, unit_enable, unit_op, unit_a, unit_b
   );
endinterface

// File: rtl/logic_unit_scheduler.sv
// Round-robin scheduler sharing one combinational bitwise unit among N_REQ requesters.
// Each operation runs IDLE (accept) -> EXEC (unit enabled, result captured) -> RESP (handshake).
module logic_unit_scheduler #(
   parameter int WIDTH = 32,
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input logic clk,
   input logic rst,
   logic_unit_scheduler_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state_reg;
   state_t state_next;

   logic [ID_W-1:0]  rr_ptr_reg;
   logic [ID_W-1:0]  id_reg;
   logic [1:0]       unit_op_reg;
   logic [WIDTH-1:0] unit_a_reg;
   logic [WIDTH-1:0] unit_b_reg;
   logic [ID_W-1:0]  rsp_id_reg;
   logic [WIDTH-1:0] rsp_data_reg;

   logic [1:0]       op_arr [N_REQ];
   logic [WIDTH-1:0] a_arr  [N_REQ];
   logic [WIDTH-1:0] b_arr  [N_REQ];

   logic             win_found;
   logic [ID_W-1:0]  win_idx;
   logic [ID_W-1:0]  rr_ptr_next;
   logic             accept;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_slice
         assign op_arr[gi] = bus.req_op[2*gi +: 2];
         assign a_arr[gi]  = bus.req_a[WIDTH*gi +: WIDTH];
         assign b_arr[gi]  = bus.req_b[WIDTH*gi +: WIDTH];
      end
   endgenerate

   // Scan offsets from the far end down so the nearest valid requester to rr_ptr wins last.
   always_comb begin
      logic [ID_W:0] slot;
      win_found = 1'b0;
      win_idx   = '0;
      slot      = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         slot = {1'b0, rr_ptr_reg} + (ID_W+1)'(i);
         if (slot >= (ID_W+1)'(N_REQ)) begin
            slot = slot - (ID_W+1)'(N_REQ);
         end
         if (bus.req_valid[slot[ID_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = slot[ID_W-1:0];
         end
      end
   end

   assign accept      = (state_reg == IDLE) && win_found;
   assign rr_ptr_next = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (win_found) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (bus.rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready   = '0;
      bus.unit_enable = 1'b0;
      bus.rsp_valid   = 1'b0;
      case (state_reg)
         IDLE:    if (win_found) bus.req_ready[win_idx] = 1'b1;
         EXEC:    bus.unit_enable = 1'b1;
         RESP:    bus.rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // Operands hold after EXEC so the unit inputs only change on a new accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_reg   <= '0;
         id_reg       <= '0;
         unit_op_reg  <= '0;
         unit_a_reg   <= '0;
         unit_b_reg   <= '0;
         rsp_id_reg   <= '0;
         rsp_data_reg <= '0;
      end else begin
         if (accept) begin
            rr_ptr_reg  <= rr_ptr_next;
            id_reg      <= win_idx;
            unit_op_reg <= op_arr[win_idx];
            unit_a_reg  <= a_arr[win_idx];
            unit_b_reg  <= b_arr[win_idx];
         end
         if (state_reg == EXEC) begin
            rsp_data_reg <= bus.unit_o;
            rsp_id_reg   <= id_reg;
         end
      end
   end

   assign bus.unit_op  = unit_op_reg;
   assign bus.unit_a   = unit_a_reg;
   assign bus.unit_b   = unit_b_reg;
   assign bus.rsp_id   = rsp_id_reg;
   assign bus.rsp_data = rsp_data_reg;

endmodule

// File: tb/tb_logic_unit_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level model of the round-robin scheduler and the bitwise unit.
module tb_logic_unit_scheduler;
   localparam int WIDTH = 32;
   localparam int N     = 4;
   localparam int IDW   = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic_unit_scheduler_if #(.WIDTH(WIDTH), .N_REQ(N), .ID_W(IDW)) ifc ();

   logic_unit_scheduler #(.WIDTH(WIDTH), .N_REQ(N), .ID_W(IDW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   logic [N-1:0]     valid_in;
   logic             rsp_ready_in;
   logic [1:0]       op_in [N];
   logic [WIDTH-1:0] a_in  [N];
   logic [WIDTH-1:0] b_in  [N];

   assign ifc.req_valid = valid_in;
   assign ifc.rsp_ready = rsp_ready_in;
   for (genvar g = 0; g < N; g++) begin : g_pack
      assign ifc.req_op[2*g +: 2]       = op_in[g];
      assign ifc.req_a[WIDTH*g +: WIDTH] = a_in[g];
      assign ifc.req_b[WIDTH*g +: WIDTH] = b_in[g];
   end

   // Shared bitwise unit: output forced to zero while not enabled.
   logic [WIDTH-1:0] unit_res;
   always_comb begin
      unit_res = '0;
      case (ifc.unit_op)
         2'd0: unit_res = ifc.unit_a & ifc.unit_b;
         2'd1: unit_res = ifc.unit_a | ifc.unit_b;
         2'd2: unit_res = (ifc.unit_a | ifc.unit_b) & ~(ifc.unit_a & ifc.unit_b);
         2'd3: unit_res = ~ifc.unit_a & ~ifc.unit_b;
         default: unit_res = '0;
      endcase
   end
   assign ifc.unit_o = ifc.unit_enable ? unit_res : '0;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: one operation in flight, phase counts cycles since accept.
   bit               m_known = 1'b0;
   int               m_phase = 0;
   int               m_ptr   = 0;
   int               m_id    = 0;
   int               m_rid   = 0;
   logic [1:0]       m_op    = '0;
   logic [WIDTH-1:0] m_a     = '0;
   logic [WIDTH-1:0] m_b     = '0;
   logic [WIDTH-1:0] m_data  = '0;
   int               grants[$];

   function automatic logic [WIDTH-1:0] ref_fn(logic [1:0] op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~(a | b);
      endcase
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check this cycle's outputs, advance the model across the next edge, then wait for it.
   task automatic tick();
      logic [N-1:0] exp_ready;
      int w;
      #1;
      exp_ready = '0;
      w = -1;
      if (m_phase == 0) begin
         for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (w < 0 && valid_in[k]) w = k;
         end
      end
      if (w >= 0) exp_ready[w] = 1'b1;
      if (m_known) begin
         chk("req_ready",   ifc.req_ready,   exp_ready);
         chk("unit_enable", ifc.unit_enable, m_phase == 1);
         chk("rsp_valid",   ifc.rsp_valid,   m_phase == 2);
         chk("rsp_id",      ifc.rsp_id,      m_rid);
         chk("rsp_data",    ifc.rsp_data,    m_data);
         chk("unit_op",     ifc.unit_op,     m_op);
         chk("unit_a",      ifc.unit_a,      m_a);
         chk("unit_b",      ifc.unit_b,      m_b);
      end
      if (rst) begin
         m_known = 1'b1;
         m_phase = 0; m_ptr = 0; m_id = 0; m_rid = 0;
         m_op = '0; m_a = '0; m_b = '0; m_data = '0;
      end else begin
         case (m_phase)
            0: if (w >= 0) begin
                  grants.push_back(w);
                  m_ptr = (w + 1) % N;
                  m_id = w; m_op = op_in[w]; m_a = a_in[w]; m_b = b_in[w];
                  m_phase = 1;
               end
            1: begin
                  m_data = ref_fn(m_op, m_a, m_b);
                  m_rid = m_id;
                  m_phase = 2;
               end
            default: if (rsp_ready_in) m_phase = 0;
         endcase
      end
      @(negedge clk);
   endtask

   logic [WIDTH-1:0] exp_sweep [4];
   int ord_all  [6];
   int ord_wrap [4];

   initial begin
      exp_sweep = '{32'h0F00_0F00, 32'hFFF0_FFF0, 32'hF0F0_F0F0, 32'h000F_000F};
      ord_all   = '{0, 1, 2, 3, 0, 1};
      ord_wrap  = '{3, 0, 3, 0};
      rst = 1'b1; valid_in = '0; rsp_ready_in = 1'b0;
      for (int k = 0; k < N; k++) begin
         op_in[k] = '0; a_in[k] = '0; b_in[k] = '0;
      end
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;

      // Single requester OR
      rsp_ready_in = 1'b1;
      valid_in = 4'b0001; op_in[0] = 2'd1; a_in[0] = 32'hF0F0_0000; b_in[0] = 32'h0000_0F0F;
      #1 chk("t1_grant", ifc.req_ready, 4'b0001);
      tick();
      valid_in = '0;
      #1 chk("t1_enable", ifc.unit_enable, 1'b1);
      tick();
      #1 chk("t1_data", ifc.rsp_data, 32'hF0F0_0F0F);
      chk("t1_valid", ifc.rsp_valid, 1'b1);
      tick();
      tick();

      // Opcode sweep on requester 2
      for (int op = 0; op < 4; op++) begin
         valid_in = 4'b0100; op_in[2] = 2'(op); a_in[2] = 32'hFF00_FF00; b_in[2] = 32'h0FF0_0FF0;
         tick();
         valid_in = '0;
         tick();
         #1 chk("sweep_data", ifc.rsp_data, exp_sweep[op]);
         chk("sweep_id", ifc.rsp_id, 2);
         tick();
      end

      // All four valid from reset
      rst = 1'b1; tick(); rst = 1'b0;
      grants.delete();
      valid_in = 4'b1111;
      for (int k = 0; k < N; k++) begin
         op_in[k] = 2'($urandom); a_in[k] = $urandom; b_in[k] = $urandom;
      end
      repeat (18) tick();
      valid_in = '0;
      chk("rr_count", grants.size(), 6);
      for (int i = 0; i < 6 && i < grants.size(); i++) chk("rr_order", grants[i], ord_all[i]);

      // Backpressure with requester 1 pending
      grants.delete();
      valid_in = 4'b0011; rsp_ready_in = 1'b0;
      tick();
      tick();
      repeat (5) tick();
      rsp_ready_in = 1'b1;
      tick();
      #1 chk("bp_grant", ifc.req_ready, 4'b0010);
      tick();
      valid_in = '0;
      tick();
      tick();
      chk("bp_count", grants.size(), 2);
      if (grants.size() == 2) chk("bp_second", grants[1], 1);

      // Reset during EXEC drops the operation
      valid_in = 4'b1000;
      tick();
      valid_in = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1 chk("rst_valid", ifc.rsp_valid, 1'b0);
      chk("rst_a", ifc.unit_a, 0);
      grants.delete();
      valid_in = 4'b1111;
      repeat (12) tick();
      valid_in = '0;
      chk("rst_count", grants.size(), 4);
      for (int i = 0; i < 4 && i < grants.size(); i++) chk("rst_order", grants[i], i);

      // Pointer wrap between requesters 3 and 0
      valid_in = 4'b0100;
      tick();
      valid_in = '0;
      tick();
      tick();
      grants.delete();
      valid_in = 4'b1001;
      repeat (12) tick();
      valid_in = '0;
      chk("wrap_count", grants.size(), 4);
      for (int i = 0; i < 4 && i < grants.size(); i++) chk("wrap_order", grants[i], ord_wrap[i]);

      // Randomized traffic with occasional reset and backpressure
      for (int c = 0; c < 400; c++) begin
         valid_in = N'($urandom);
         rsp_ready_in = ($urandom_range(3) != 0);
         rst = ($urandom_range(60) == 0);
         for (int k = 0; k < N; k++) begin
            op_in[k] = 2'($urandom); a_in[k] = $urandom; b_in[k] = $urandom;
         end
         tick();
      end
      rst = 1'b0; valid_in = '0; rsp_ready_in = 1'b1;
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
